// File: rtl/mem_pkg.sv
// mem_pkg
// Shared definitions for the MEM stage: the data-memory handshake FSM states,
// the funct3 size/sign encodings for loads and stores, and the byte-strobe width.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int STRB_W = 4;

endpackage

// File: rtl/load_align.sv
// load_align
// Combinational load data aligner. Picks the addressed byte or halfword out of
// the returned memory word and sign- or zero-extends it according to funct3.
// Halfwords are selected by addr_lo[1] only; addr_lo[0] is ignored for them.
// Ports:
//   rdata   in  32  raw word from data memory
//   addr_lo in  2   byte offset latched when the request was issued
//   funct3  in  3   load size/sign (B, H, W, BU, HU)
//   result  out 32  aligned and extended load value
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[8*addr_lo +: 8];
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    result = rdata;
    case (funct3)
      F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    result = {{16{half_sel[15]}}, half_sel};
      F3_BU:   result = {24'b0, byte_sel};
      F3_HU:   result = {16'b0, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage
// MEM stage of the 5-stage RV32I core. Each load/store runs one data-memory
// transaction over a req/gnt/rvalid handshake while DM_busy holds the pipeline;
// non-memory instructions pass ex_alu_out straight through with no stall.
// Optional feature macro: MEM_MISALIGN_CHECK_EN (flags misaligned H/HU/W
// accesses, suppresses their request and writeback). When undefined, low
// address bits that do not fit the access size are silently dropped.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   ex_valid, ex_mem_read, ex_mem_write, ex_funct3, ex_alu_out, ex_wdata,
//   ex_reg_write, ex_rd      instruction from EX/MEM
//   dm_req, dm_we, dm_addr, dm_wstrb, dm_wdata   request to data memory
//   dm_gnt, dm_rvalid, dm_rdata                  grant / response from memory
//   DM_busy                  pipeline stall
//   MEM_WB_RegWrite, MEM_WB_Rd, WB_RegData_in    writeback register inputs
//   misalign                 misaligned-access pulse
module mem_access_stage
  import mem_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                ex_valid,
  input  logic                ex_mem_read,
  input  logic                ex_mem_write,
  input  logic [2:0]          ex_funct3,
  input  logic [31:0]         ex_alu_out,
  input  logic [31:0]         ex_wdata,
  input  logic                ex_reg_write,
  input  logic [4:0]          ex_rd,
  output logic                dm_req,
  output logic                dm_we,
  output logic [31:0]         dm_addr,
  output logic [STRB_W-1:0]   dm_wstrb,
  output logic [31:0]         dm_wdata,
  input  logic                dm_gnt,
  input  logic                dm_rvalid,
  input  logic [31:0]         dm_rdata,
  output logic                DM_busy,
  output logic                MEM_WB_RegWrite,
  output logic [4:0]          MEM_WB_Rd,
  output logic [31:0]         WB_RegData_in,
  output logic                misalign
);

  state_t            state;
  logic              access;
  logic              start;
  logic [1:0]        addr_lo;
  logic [STRB_W-1:0] strb_next;
  logic [31:0]       wdata_next;
  logic [1:0]        addr_lo_q;
  logic [2:0]        funct3_q;
  logic              load_q;
  logic [31:0]       load_data;

  assign addr_lo = ex_alu_out[1:0];
  assign access  = ex_valid & (ex_mem_read | ex_mem_write);

`ifdef MEM_MISALIGN_CHECK_EN
  // Only a fresh access in IDLE can be flagged; suppressed while in reset.
  assign misalign = ~rst && (state == IDLE) && access &&
                    (((ex_funct3[1:0] == 2'b01) && addr_lo[0]) ||
                     ((ex_funct3[1:0] == 2'b10) && (addr_lo != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  assign start = (state == IDLE) & access & ~misalign;

  // Lane placement for stores: replicate the datum across the word and let the
  // strobe pick the lanes. Loads carry an all-zero strobe and zero data.
  always_comb begin
    strb_next  = '0;
    wdata_next = '0;
    if (ex_mem_write) begin
      case (ex_funct3[1:0])
        2'b00: begin
          strb_next  = 4'b0001 << addr_lo;
          wdata_next = {4{ex_wdata[7:0]}};
        end
        2'b01: begin
          strb_next  = 4'b0011 << {addr_lo[1], 1'b0};
          wdata_next = {2{ex_wdata[15:0]}};
        end
        default: begin
          strb_next  = 4'b1111;
          wdata_next = ex_wdata;
        end
      endcase
    end
  end

  // Handshake FSM. Request fields are captured on entry to REQ so they stay
  // stable until the grant; the byte offset and funct3 are kept for alignment
  // of the response, since dm_addr has its low bits cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      dm_we     <= 1'b0;
      dm_addr   <= '0;
      dm_wstrb  <= '0;
      dm_wdata  <= '0;
      addr_lo_q <= '0;
      funct3_q  <= '0;
      load_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dm_we     <= ex_mem_write;
            dm_addr   <= {ex_alu_out[31:2], 2'b00};
            dm_wstrb  <= strb_next;
            dm_wdata  <= wdata_next;
            addr_lo_q <= addr_lo;
            funct3_q  <= ex_funct3;
            load_q    <= ex_mem_read;
            state     <= REQ;
          end
        end
        REQ: begin
          if (dm_gnt) state <= RESP;
        end
        RESP: begin
          if (dm_rvalid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dm_req = (state == REQ);

  assign DM_busy = start | (state == REQ) | ((state == RESP) & ~dm_rvalid);

  load_align u_load_align (
    .rdata   (dm_rdata),
    .addr_lo (addr_lo_q),
    .funct3  (funct3_q),
    .result  (load_data)
  );

  assign WB_RegData_in   = ((state == RESP) && dm_rvalid && load_q) ? load_data : ex_alu_out;
  assign MEM_WB_RegWrite = ex_valid & ex_reg_write & ~misalign;
  assign MEM_WB_Rd       = ex_rd;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage
// Directed bench for the MEM stage. Inputs change on the falling edge, outputs
// are compared 1 ns later, so every check sits half a cycle from the active edge.
// Honours MEM_MISALIGN_CHECK_EN for the misaligned-word case.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_mem_read, ex_mem_write, ex_reg_write;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_alu_out, ex_wdata;
  logic [4:0]  ex_rd;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic [3:0]  dm_wstrb;
  logic        dm_gnt, dm_rvalid;
  logic [31:0] dm_rdata;
  logic        DM_busy, MEM_WB_RegWrite, misalign;
  logic [4:0]  MEM_WB_Rd;
  logic [31:0] WB_RegData_in;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_access_stage dut (
    .clk             (clk),
    .rst             (rst),
    .ex_valid        (ex_valid),
    .ex_mem_read     (ex_mem_read),
    .ex_mem_write    (ex_mem_write),
    .ex_funct3       (ex_funct3),
    .ex_alu_out      (ex_alu_out),
    .ex_wdata        (ex_wdata),
    .ex_reg_write    (ex_reg_write),
    .ex_rd           (ex_rd),
    .dm_req          (dm_req),
    .dm_we           (dm_we),
    .dm_addr         (dm_addr),
    .dm_wstrb        (dm_wstrb),
    .dm_wdata        (dm_wdata),
    .dm_gnt          (dm_gnt),
    .dm_rvalid       (dm_rvalid),
    .dm_rdata        (dm_rdata),
    .DM_busy         (DM_busy),
    .MEM_WB_RegWrite (MEM_WB_RegWrite),
    .MEM_WB_Rd       (MEM_WB_Rd),
    .WB_RegData_in   (WB_RegData_in),
    .misalign        (misalign)
  );

  // Drives a new EX/MEM instruction onto the stage inputs.
  task automatic applyStimulus(input logic v, input logic rd_en, input logic wr_en,
                               input logic [2:0] f3, input logic [31:0] alu,
                               input logic [31:0] wd, input logic rw, input logic [4:0] rd);
    ex_valid     = v;
    ex_mem_read  = rd_en;
    ex_mem_write = wr_en;
    ex_funct3    = f3;
    ex_alu_out   = alu;
    ex_wdata     = wd;
    ex_reg_write = rw;
    ex_rd        = rd;
  endtask

  // One comparison: counts it and reports a miscompare with tag and values.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Advance to the next falling edge (the point where inputs change).
  task automatic nextCycle();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = 32'h0;
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 5'd0);
    repeat (2) @(posedge clk);
    nextCycle(); #1;
    $display("[TB] reset state");
    checkOutput("rst_req",   {31'b0, dm_req}, 32'h0);
    checkOutput("rst_we",    {31'b0, dm_we},  32'h0);
    checkOutput("rst_addr",  dm_addr,         32'h0);
    checkOutput("rst_wstrb", {28'b0, dm_wstrb}, 32'h0);
    checkOutput("rst_wdata", dm_wdata,        32'h0);
    checkOutput("rst_busy",  {31'b0, DM_busy}, 32'h0);
    checkOutput("rst_mis",   {31'b0, misalign}, 32'h0);
    rst = 1'b0;

    // ALU op: zero-cycle passthrough
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0, 1'b1, 5'd7);
    #1;
    checkOutput("alu_busy", {31'b0, DM_busy}, 32'h0);
    checkOutput("alu_wb",   WB_RegData_in, 32'h0000_1234);
    checkOutput("alu_rw",   {31'b0, MEM_WB_RegWrite}, 32'h1);
    checkOutput("alu_rd",   {27'b0, MEM_WB_Rd}, 32'd7);
    nextCycle(); #1;
    checkOutput("alu_noreq", {31'b0, dm_req}, 32'h0);

    // SB 0x1003, rs2=0xAB, immediate grant
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b1, 3'b000, 32'h0000_1003, 32'h0000_00AB, 1'b0, 5'd0);
    #1;
    checkOutput("sb_c0_busy", {31'b0, DM_busy}, 32'h1);
    checkOutput("sb_c0_req",  {31'b0, dm_req}, 32'h0);
    nextCycle(); #1;
    checkOutput("sb_req",   {31'b0, dm_req}, 32'h1);
    checkOutput("sb_we",    {31'b0, dm_we}, 32'h1);
    checkOutput("sb_addr",  dm_addr, 32'h0000_1000);
    checkOutput("sb_wstrb", {28'b0, dm_wstrb}, 32'h8);
    checkOutput("sb_wdata", dm_wdata, 32'hABAB_ABAB);
    checkOutput("sb_c1_busy", {31'b0, DM_busy}, 32'h1);
    dm_gnt = 1'b1;
    nextCycle();
    dm_gnt = 1'b0; dm_rvalid = 1'b1;
    #1;
    checkOutput("sb_c2_busy", {31'b0, DM_busy}, 32'h0);
    checkOutput("sb_c2_req",  {31'b0, dm_req}, 32'h0);
    checkOutput("sb_c2_rw",   {31'b0, MEM_WB_RegWrite}, 32'h0);

    // LB 0x2001, grant after 3 wait cycles, one rvalid wait
    nextCycle();
    dm_rvalid = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 3'b000, 32'h0000_2001, 32'h0, 1'b1, 5'd5);
    #1;
    checkOutput("lb_c0_busy", {31'b0, DM_busy}, 32'h1);
    nextCycle(); #1;
    checkOutput("lb_addr",  dm_addr, 32'h0000_2000);
    checkOutput("lb_wstrb", {28'b0, dm_wstrb}, 32'h0);
    checkOutput("lb_we",    {31'b0, dm_we}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      nextCycle(); #1;
      checkOutput("lb_wait_req",  {31'b0, dm_req}, 32'h1);
      checkOutput("lb_wait_busy", {31'b0, DM_busy}, 32'h1);
    end
    dm_gnt = 1'b1;
    nextCycle();
    dm_gnt = 1'b0;
    #1;
    checkOutput("lb_resp_busy", {31'b0, DM_busy}, 32'h1);
    checkOutput("lb_resp_wb",   WB_RegData_in, 32'h0000_2001);
    nextCycle();
    dm_rvalid = 1'b1; dm_rdata = 32'h0000_80FF;
    #1;
    checkOutput("lb_wb",   WB_RegData_in, 32'hFFFF_FF80);
    checkOutput("lb_busy", {31'b0, DM_busy}, 32'h0);
    checkOutput("lb_rw",   {31'b0, MEM_WB_RegWrite}, 32'h1);

    // LBU same address/data
    nextCycle();
    dm_rvalid = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 3'b100, 32'h0000_2001, 32'h0, 1'b1, 5'd5);
    nextCycle(); dm_gnt = 1'b1;
    nextCycle(); dm_gnt = 1'b0; dm_rvalid = 1'b1; dm_rdata = 32'h0000_80FF;
    #1;
    checkOutput("lbu_wb", WB_RegData_in, 32'h0000_0080);

    // LHU 0x2002 then back-to-back LW 0x2004
    nextCycle();
    dm_rvalid = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 3'b101, 32'h0000_2002, 32'h0, 1'b1, 5'd6);
    nextCycle(); dm_gnt = 1'b1;
    nextCycle(); dm_gnt = 1'b0; dm_rvalid = 1'b1; dm_rdata = 32'hBEEF_0000;
    #1;
    checkOutput("lhu_wb", WB_RegData_in, 32'h0000_BEEF);
    nextCycle();
    dm_rvalid = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_2004, 32'h0, 1'b1, 5'd8);
    #1;
    checkOutput("b2b_gap_req",  {31'b0, dm_req}, 32'h0);
    checkOutput("b2b_gap_busy", {31'b0, DM_busy}, 32'h1);
    nextCycle(); #1;
    checkOutput("lw_req",  {31'b0, dm_req}, 32'h1);
    checkOutput("lw_addr", dm_addr, 32'h0000_2004);
    dm_gnt = 1'b1;
    nextCycle(); dm_gnt = 1'b0; dm_rvalid = 1'b1; dm_rdata = 32'hCAFE_F00D;
    #1;
    checkOutput("lw_wb", WB_RegData_in, 32'hCAFE_F00D);

    // Reset while waiting in RESP
    nextCycle();
    dm_rvalid = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_4000, 32'h0, 1'b1, 5'd9);
    nextCycle(); dm_gnt = 1'b1;
    nextCycle(); dm_gnt = 1'b0;
    #1;
    checkOutput("rr_resp_busy", {31'b0, DM_busy}, 32'h1);
    rst = 1'b1;
    #1;
    checkOutput("rr_mis", {31'b0, misalign}, 32'h0);
    nextCycle();
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 5'd0);
    #1;
    checkOutput("rr_req",  {31'b0, dm_req}, 32'h0);
    checkOutput("rr_busy", {31'b0, DM_busy}, 32'h0);
    checkOutput("rr_addr", dm_addr, 32'h0);
    nextCycle();
    dm_rvalid = 1'b1; dm_rdata = 32'hDEAD_BEEF;
    applyStimulus(1'b1, 1'b0, 1'b0, 3'b000, 32'h0000_0055, 32'h0, 1'b1, 5'd3);
    #1;
    checkOutput("rr_late_wb",   WB_RegData_in, 32'h0000_0055);
    checkOutput("rr_late_busy", {31'b0, DM_busy}, 32'h0);
    nextCycle();
    dm_rvalid = 1'b0;
    #1;
    checkOutput("rr_late_req", {31'b0, dm_req}, 32'h0);

    // LW 0x3002 (misaligned word)
    nextCycle();
    applyStimulus(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_3002, 32'h0, 1'b1, 5'd4);
    #1;
`ifdef MEM_MISALIGN_CHECK_EN
    checkOutput("mis_flag", {31'b0, misalign}, 32'h1);
    checkOutput("mis_busy", {31'b0, DM_busy}, 32'h0);
    checkOutput("mis_rw",   {31'b0, MEM_WB_RegWrite}, 32'h0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 5'd0);
    #1;
    checkOutput("mis_noreq", {31'b0, dm_req}, 32'h0);
`else
    checkOutput("mis_flag", {31'b0, misalign}, 32'h0);
    checkOutput("mis_busy", {31'b0, DM_busy}, 32'h1);
    checkOutput("mis_rw",   {31'b0, MEM_WB_RegWrite}, 32'h1);
    nextCycle(); #1;
    checkOutput("mis_req",  {31'b0, dm_req}, 32'h1);
    checkOutput("mis_addr", dm_addr, 32'h0000_3000);
    dm_gnt = 1'b1;
    nextCycle(); dm_gnt = 1'b0; dm_rvalid = 1'b1; dm_rdata = 32'h1122_3344;
    #1;
    checkOutput("mis_wb", WB_RegData_in, 32'h1122_3344);
    nextCycle();
    dm_rvalid = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 5'd0);
`endif

    nextCycle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

MEM stage of the 5-stage RV32I core: takes the EX/MEM instruction, runs one data-memory transaction per load/store through a request/grant/response handshake, aligns and extends load data, and drives the writeback-register inputs. It asserts DM_busy for the whole transaction so the pipeline and the MEM/WB register hold. For non-memory instructions it passes the ALU result through in zero cycles.

## Interface
- No parameters.
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, synchronous, active-high
- ex_valid  in  1  valid instruction in MEM stage
- ex_mem_read / ex_mem_write  in  1  load / store (mutually exclusive)
- ex_funct3  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- ex_alu_out  in  32  memory address for loads/stores; result otherwise
- ex_wdata  in  32  store data (rs2)
- ex_reg_write  in  1  instruction writes rd
- ex_rd  in  5  destination register
- dm_req  out  1  request valid, held until dm_gnt
- dm_we  out  1  1 = store
- dm_addr  out  32  word address, low 2 bits forced 0
- dm_wstrb  out  4  byte-enable mask; 0000 for loads
- dm_wdata  out  32  lane-aligned store data
- dm_gnt  in  1  request accepted
- dm_rvalid  in  1  response: read data valid, or store complete
- dm_rdata  in  32  read word
- DM_busy  out  1  stall the pipeline and MEM/WB
- MEM_WB_RegWrite  out  1  writeback enable to MEM/WB
- MEM_WB_Rd  out  5  ex_rd passthrough
- WB_RegData_in  out  32  extended load data or ex_alu_out
- misalign  out  1  misaligned-access pulse (see Configuration)

## Operation
- FSM states: IDLE, REQ, RESP.
- IDLE: access = ex_valid & (ex_mem_read | ex_mem_write). If access, register dm_we/addr/wstrb/wdata and go to REQ.
- REQ: dm_req = 1. On dm_gnt, go to RESP. dm_rvalid is ignored in REQ.
- RESP: on dm_rvalid, go to IDLE.
- DM_busy = (IDLE & access) | REQ | (RESP & ~dm_rvalid). It is combinational. Upstream holds the ex_* inputs stable while it is high.
- Store lanes, with a = ex_alu_out[1:0]:
  - SB: wstrb = 0001<<a, wdata = {4{byte}}.
  - SH: wstrb = 0011<<{a[1],0}, wdata = {2{half}}.
  - SW: wstrb = 1111, wdata = rs2.
- Load: select byte dm_rdata[8a+:8] or half dm_rdata[16a[1]+:16]. Sign-extend for B/H, zero-extend for BU/HU. Use the address latched at request time.
- WB_RegData_in = aligned dm_rdata in the RESP & dm_rvalid cycle of a load; otherwise ex_alu_out.
- MEM_WB_RegWrite = ex_valid & ex_reg_write & ~misalign. It is high only in cycles where DM_busy = 0 is meaningful.
- An unsolicited dm_rvalid in IDLE is ignored.

## Timing
- Reset values: state IDLE; dm_req, dm_we, dm_addr, dm_wstrb, dm_wdata all 0.
- Combinational outputs follow their inputs during reset: DM_busy and MEM_WB_RegWrite from ex_*; misalign is 0 while rst is high.
- Minimum access: access seen in cycle 0 (busy=1), dm_req in cycle 1 with gnt, dm_rvalid in cycle 2 (busy=0, MEM/WB captures at end of cycle 2). That is 2 stall cycles.
- Each wait cycle on gnt or rvalid adds one stall cycle.
- dm_req, addr, we, wstrb and wdata stay stable from REQ entry until the gnt cycle.
- Back-to-back accesses: the FSM returns to IDLE on rvalid. The next instruction's access starts in the following cycle.
- rst mid-transaction: FSM returns to IDLE and dm_req drops next edge. The outstanding response is discarded.

## Configuration
- MEM_MISALIGN_CHECK_EN defined:
  - Misaligned accesses are H/HU with addr[0]=1 and W with addr[1:0]≠0.
  - A misaligned access issues no request and DM_busy stays 0.
  - misalign = 1 for that cycle and MEM_WB_RegWrite = 0.
- Undefined: misalign is tied 0. Low address bits are silently dropped: H uses addr[1], W ignores addr[1:0].

## Structure
- Package mem_pkg holds the state enum (IDLE/REQ/RESP), the funct3 size/sign constants, and the strobe width constant.
- Sub-module load_align (combinational): rdata, addr[1:0] and funct3 in; 32-bit extended result out. Instantiated once.

## Test plan
- ALU op (no mem), ex_alu_out=0x1234 -> DM_busy=0, WB_RegData_in=0x1234, no dm_req.
- SB addr 0x1003, rs2=0xAB, gnt immediate -> dm_addr 0x1000, wstrb 1000, wdata 0xABABABAB; busy 2 cycles.
- LB addr 0x2001, rdata 0x0000_80FF, gnt after 3 wait cycles -> WB_RegData_in 0xFFFF_FF80 on rvalid cycle; LBU same case -> 0x0000_0080.
- LHU addr 0x2002, rdata 0xBEEF_0000 -> 0x0000_BEEF; back-to-back LW follows with one IDLE cycle between the two requests.
- rst asserted while in RESP -> next cycle IDLE, dm_req=0; a later dm_rvalid is ignored.
- LW addr 0x3002 with MEM_MISALIGN_CHECK_EN -> misalign=1, no dm_req, MEM_WB_RegWrite=0; without the macro -> dm_addr 0x3000.
